// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared core constants and fetch FSM encoding
package instruction_fetch_pkg;

    localparam int TIMEOUT_CYCLES_DEF = 255;
    localparam int TIMEOUT_W_MIN      = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ADVANCE,
        S_ERR
    } fetch_state_t;

    // Timeout counter width: enough for 0..limit-1, never below 8 bits
    function automatic int cnt_width(input int limit);
        return ($clog2(limit) > TIMEOUT_W_MIN) ? $clog2(limit) : TIMEOUT_W_MIN;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding-read fetch FSM with alignment and timeout faults
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_PC,
    output logic        o_load_PC,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_read,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_DV,
    output logic [31:0] o_instr,
    output logic        o_instr_DV,
    input  logic        i_instr_ack,
    output logic        o_misaligned,
    output logic        o_bus_error
);

    localparam int            CW    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    fetch_state_t  r_state;
    logic [CW-1:0] r_cnt;
    logic          r_load_pc;
    logic [31:0]   r_mem_addr;
    logic          r_mem_read;
    logic [31:0]   r_instr;
    logic          r_instr_dv;
    logic          r_misaligned;
    logic          r_bus_error;
    logic          w_misaligned;

    assign w_misaligned = |i_PC[1:0];
    assign o_load_PC    = r_load_pc;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_read   = r_mem_read;
    assign o_instr      = r_instr;
    assign o_instr_DV   = r_instr_dv;
    assign o_misaligned = r_misaligned;
    assign o_bus_error  = r_bus_error;

    // Fetch FSM; strobes default low so each pulse lasts exactly one cycle, data beats timeout
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_load_pc    <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_read   <= 1'b0;
            r_instr      <= 32'h0;
            r_instr_dv   <= 1'b0;
            r_misaligned <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            r_load_pc  <= 1'b0;
            r_mem_read <= 1'b0;
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (w_misaligned) begin
                        r_misaligned <= 1'b1;
                        r_state      <= S_ERR;
                    end else begin
                        r_mem_addr <= i_PC;
                        r_mem_read <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_mem_DV) begin
                        r_instr    <= i_mem_data;
                        r_instr_dv <= 1'b1;
                        r_state    <= S_HOLD;
                    end else if (r_cnt == LIMIT) begin
                        r_bus_error <= 1'b1;
                        r_state     <= S_ERR;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_HOLD: begin
                    if (i_instr_ack) begin
                        r_instr_dv <= 1'b0;
                        r_load_pc  <= 1'b1;
                        r_state    <= S_ADVANCE;
                    end
                end
                S_ADVANCE: r_state <= S_REQ;
                default:   r_state <= S_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: PC/memory/decode environment with an instruction scoreboard
module tb_instruction_fetch;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_PC = 32'h0;
    logic        o_load_PC;
    logic [31:0] o_mem_addr;
    logic        o_mem_read;
    logic [31:0] i_mem_data = 32'h0;
    logic        i_mem_DV = 1'b0;
    logic [31:0] o_instr;
    logic        o_instr_DV;
    logic        i_instr_ack = 1'b0;
    logic        o_misaligned;
    logic        o_bus_error;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] pc;
    int          lat;
    int          ack_dly;
    int          cd;
    int          dv_cnt;
    int          n_done;
    int          n_load;
    logic        prev_load;
    logic        prev_read;
    logic        in_wait;
    logic [31:0] cur_addr;
    logic [31:0] exp_q[$];

    instruction_fetch #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_PC(i_PC),
        .o_load_PC(o_load_PC),
        .o_mem_addr(o_mem_addr),
        .o_mem_read(o_mem_read),
        .i_mem_data(i_mem_data),
        .i_mem_DV(i_mem_DV),
        .o_instr(o_instr),
        .o_instr_DV(o_instr_DV),
        .i_instr_ack(i_instr_ack),
        .o_misaligned(o_misaligned),
        .o_bus_error(o_bus_error)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h00500093 : (a * 32'h9E3779B1) + 32'h13;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: advance PC register, memory and decode models, check, then drive inputs
    task automatic step();
        logic dv;
        logic ack;
        @(posedge i_clk);
        #1;
        if (prev_load) pc += 32'd4;
        if (o_load_PC) begin
            check("load_width", {31'b0, prev_load}, 32'h0);
            n_load++;
        end
        prev_load = o_load_PC;
        dv = (cd == 1);
        if (cd > 0) cd--;
        if (o_mem_read) begin
            check("read_width", {31'b0, prev_read}, 32'h0);
            check("read_addr", o_mem_addr, pc);
            exp_q.push_back(mem_word(pc));
            cur_addr = o_mem_addr;
            cd = lat;
            in_wait = 1'b1;
        end else if (in_wait) begin
            check("addr_stable", o_mem_addr, cur_addr);
        end
        prev_read = o_mem_read;
        ack = 1'b0;
        if (o_instr_DV) begin
            if (dv_cnt == 0) begin
                in_wait = 1'b0;
                if (exp_q.size() == 0) check("instr_unexpected", 32'h1, 32'h0);
                else check("instr", o_instr, exp_q.pop_front());
            end
            ack = (dv_cnt >= ack_dly);
            dv_cnt++;
        end else begin
            if (dv_cnt != 0) begin
                check("dv_len", dv_cnt, ack_dly + 1);
                n_done++;
            end
            dv_cnt = 0;
        end
        i_mem_DV    = dv;
        i_mem_data  = dv ? mem_word(cur_addr) : 32'h0;
        i_instr_ack = ack;
        i_PC        = pc;
    endtask

    task automatic clear_models(input logic [31:0] pc0, input int lat_v, input int ack_v);
        pc        = pc0;
        lat       = lat_v;
        ack_dly   = ack_v;
        cd        = 0;
        dv_cnt    = 0;
        n_done    = 0;
        n_load    = 0;
        prev_load = 1'b0;
        prev_read = 1'b0;
        in_wait   = 1'b0;
        cur_addr  = 32'h0;
        exp_q.delete();
        i_PC        = pc0;
        i_mem_DV    = 1'b0;
        i_mem_data  = 32'h0;
        i_instr_ack = 1'b0;
    endtask

    task automatic do_reset(input logic [31:0] pc0, input int lat_v, input int ack_v);
        i_rst = 1'b1;
        clear_models(pc0, lat_v, ack_v);
        step();
        step();
        check("rst_flags", {27'b0, o_load_PC, o_mem_read, o_instr_DV, o_misaligned, o_bus_error}, 32'h0);
        check("rst_addr", o_mem_addr, 32'h0);
        check("rst_instr", o_instr, 32'h0);
    endtask

    task automatic release_expect_read();
        i_rst = 1'b0;
        step();
        check("read_early", {31'b0, o_mem_read}, 32'h0);
        step();
        check("first_read", {31'b0, o_mem_read}, 32'h1);
    endtask

    task automatic run_instr(input int n, input int budget);
        int k = 0;
        while (n_done < n && k < budget) begin
            step();
            k++;
        end
        check("instr_count", n_done, n);
    endtask

    initial begin
        int k;
        logic seen_read;
        logic seen_load;
        logic seen_dv;
        logic [31:0] held;

        do_reset(32'h0, 1, 0);
        release_expect_read();
        check("first_addr", o_mem_addr, 32'h0);
        run_instr(2, 40);
        check("second_read_addr", cur_addr, 32'h4);
        check("loads_basic", n_load, n_done);

        do_reset(32'h200, 10, 5);
        release_expect_read();
        run_instr(3, 200);
        check("loads_slow", n_load, 3);

        do_reset(32'h300, 6, 3);
        release_expect_read();
        step();
        i_instr_ack = 1'b1;
        step();
        check("spur_ack_dv", {31'b0, o_instr_DV}, 32'h0);
        check("spur_ack_load", {31'b0, o_load_PC}, 32'h0);
        k = 0;
        while (!o_instr_DV && k < 20) begin
            step();
            k++;
        end
        check("hold_reached", {31'b0, o_instr_DV}, 32'h1);
        held = o_instr;
        i_mem_DV = 1'b1;
        i_mem_data = 32'hDEADBEEF;
        step();
        check("spur_dv_instr", o_instr, held);
        check("spur_dv_valid", {31'b0, o_instr_DV}, 32'h1);
        run_instr(2, 60);

        do_reset(32'h6, 1, 0);
        i_rst = 1'b0;
        seen_read = 1'b0;
        seen_load = 1'b0;
        step();
        step();
        check("misaligned_set", {31'b0, o_misaligned}, 32'h1);
        repeat (10) begin
            step();
            seen_read |= o_mem_read;
            seen_load |= o_load_PC;
        end
        check("misalign_quiet", {30'b0, seen_read, seen_load}, 32'h0);
        check("misaligned_held", {31'b0, o_misaligned}, 32'h1);

        do_reset(32'h100, 0, 0);
        release_expect_read();
        k = 0;
        while (!o_bus_error && k < 40) begin
            step();
            k++;
        end
        check("timeout_cycles", k, 16);
        seen_read = 1'b0;
        seen_load = 1'b0;
        seen_dv = 1'b0;
        repeat (5) begin
            step();
            seen_read |= o_mem_read;
            seen_load |= o_load_PC;
            seen_dv |= o_instr_DV;
        end
        check("err_quiet", {29'b0, seen_read, seen_load, seen_dv}, 32'h0);
        check("bus_error_held", {30'b0, o_bus_error, o_misaligned}, 32'h2);

        do_reset(32'h80, 15, 0);
        release_expect_read();
        run_instr(1, 60);
        check("limit_data_wins", {31'b0, o_bus_error}, 32'h0);

        do_reset(32'h80, 16, 0);
        release_expect_read();
        repeat (20) step();
        check("limit_plus_one", {30'b0, o_bus_error, o_instr_DV}, 32'h2);

        do_reset(32'h40, 8, 0);
        release_expect_read();
        repeat (3) step();
        check("mid_wait_addr", o_mem_addr, 32'h40);
        #3;
        i_rst = 1'b1;
        #1;
        check("async_flags", {27'b0, o_load_PC, o_mem_read, o_instr_DV, o_misaligned, o_bus_error}, 32'h0);
        check("async_addr", o_mem_addr, 32'h0);
        clear_models(32'h40, 8, 0);
        i_mem_DV = 1'b1;
        i_mem_data = 32'hBAD0BAD0;
        step();
        i_mem_DV = 1'b1;
        i_mem_data = 32'hBAD0BAD0;
        release_expect_read();
        check("fresh_read_addr", o_mem_addr, 32'h40);
        run_instr(1, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
